// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Shifts stream bytes into a big-endian word; the first byte lands in the top byte lane.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_ready_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (shift_i) begin
      word_d = {word_q[WORD_W-9:0], byte_i};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  // The word is complete on the transfer that fills the last byte lane.
  assign word_ready_o = shift_i && !clear_i && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = word_q;

endmodule

// File: rtl/inst_loader.sv
// Byte-stream instruction-memory writer that holds the CPU while loading.
// Optional trailing XOR checksum byte: define INST_LOADER_CHECKSUM_EN.
module inst_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 101,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              xfer;
  logic              asm_clear;
  logic              asm_shift;
  logic              word_ready;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

`ifdef INST_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == RECV) || (state_q == CHECK);
`else
  assign byte_ready = (state_q == RECV);
`endif
  assign xfer      = byte_valid && byte_ready;
  assign asm_shift = xfer && (state_q == RECV);

  byte_assembler u_asm (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (asm_clear),
    .shift_i      (asm_shift),
    .byte_i       (byte_in),
    .word_o       (wr_data),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    num_d     = num_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    asm_clear = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      IDLE: begin
        // Keep the byte index parked at zero so every load starts on a word boundary.
        asm_clear = 1'b1;
        if (start) begin
          if (num_words == '0) begin
            state_d = DONE;
          end else if (num_words > ADDR_W'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            num_d   = num_words;
            addr_d  = '0;
            state_d = RECV;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_d   = 8'h00;
`endif
          end
        end
      end
      RECV: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (xfer) xor_d = xor_q ^ byte_in;
`endif
        if (word_ready) state_d = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        // The address holds on the final word so it never points past the memory.
        if (addr_q == num_q - ADDR_W'(1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (byte_in == xor_q) begin
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      num_q   <= num_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // done is registered off the DONE state, so it coincides with busy falling.
  assign busy     = (state_q != IDLE);
  assign cpu_hold = busy;
  assign wr_addr  = addr_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (checksum tests need INST_LOADER_CHECKSUM_EN).
module tb_inst_loader;

  localparam int DEPTH  = 101;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] num_words = '0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lastXferCyc = -10;
  int doneCount = 0;
  int errCount = 0;
  int busyCount = 0;
  int holdLow = 0;
  int latencyBad = 0;
  int overlapCount = 0;
  bit watchHold = 1'b0;
  logic [ADDR_W-1:0] wrAddrQ[$];
  logic [31:0]       wrDataQ[$];
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] xorAcc = 8'h00;
`endif

  inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Observe the DUT mid-cycle: log writes, pulses, write latency and hold behaviour.
  always @(negedge clk) begin
    if (wr_en) begin
      wrAddrQ.push_back(wr_addr);
      wrDataQ.push_back(wr_data);
      if (byte_ready) overlapCount = overlapCount + 1;
      if (cyc - lastXferCyc != 1) latencyBad = latencyBad + 1;
    end
    if (byte_valid && byte_ready) lastXferCyc = cyc;
    if (done) doneCount = doneCount + 1;
    if (err) errCount = errCount + 1;
    if (busy) busyCount = busyCount + 1;
    if (watchHold && !done && !cpu_hold) holdLow = holdLow + 1;
    if (done) watchHold = 1'b0;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_monitor();
    doneCount = 0;
    errCount = 0;
    busyCount = 0;
    holdLow = 0;
    latencyBad = 0;
    overlapCount = 0;
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] n);
    num_words = n;
    start = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
    xorAcc = 8'h00;
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapMax);
    int waited;
    int gap;
    gap = int'($urandom_range(gapMax, 0));
    repeat (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in = b;
    waited = 0;
    while (!byte_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_accept: byte_ready=%0b after %0d cycles, required 1", byte_ready, waited);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    xorAcc = xorAcc ^ b;
`endif
  endtask

  task automatic send_word(input logic [31:0] w, input int gapMax);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gapMax);
  endtask

  task automatic send_checksum();
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = xorAcc;
    send_byte(sum, 0);
`endif
  endtask

  task automatic wait_idle(input string name);
    int waited;
    waited = 0;
    while (busy && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", name, busy, waited);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({byte_ready, wr_en, busy, cpu_hold, done, err} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: {ready,wr_en,busy,hold,done,err}=%b required 000000",
               {byte_ready, wr_en, busy, cpu_hold, done, err});
    end
    checks++;
    if (wr_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h required 0", wr_addr);
    end
    checks++;
    if (wr_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h required 0", wr_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_two_words();
    logic [31:0] expData [2];
    expData[0] = 32'h4C00007B;
    expData[1] = 32'h4C200159;
    clear_monitor();
    pulse_start(2);
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL two_hold_start: cpu_hold=%b required 1", cpu_hold);
    end
    watchHold = 1'b1;
    send_word(expData[0], 0);
    send_word(expData[1], 0);
    send_checksum();
    wait_idle("two");
    checks++;
    if (wrAddrQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL two_count: writes=%0d required 2", wrAddrQ.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wrAddrQ.size() || wrAddrQ[i] !== ADDR_W'(i) || wrDataQ[i] !== expData[i]) begin
        errors++;
        if (i < wrAddrQ.size())
          $display("[TB] FAIL two_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                   i, wrAddrQ[i], wrDataQ[i], i, expData[i]);
        else
          $display("[TB] FAIL two_write%0d: missing, required addr=%0d data=%h", i, i, expData[i]);
      end
    end
    checks++;
    if (doneCount != 1 || errCount != 0) begin
      errors++;
      $display("[TB] FAIL two_pulses: done=%0d err=%0d required done=1 err=0", doneCount, errCount);
    end
    checks++;
    if (holdLow != 0) begin
      errors++;
      $display("[TB] FAIL two_hold: cpu_hold low for %0d cycles before done, required 0", holdLow);
    end
    checks++;
    if (latencyBad != 0) begin
      errors++;
      $display("[TB] FAIL two_latency: %0d writes not one cycle after 4th byte, required 0", latencyBad);
    end
    watchHold = 1'b0;
  endtask

  task automatic test_zero_words();
    clear_monitor();
    pulse_start(0);
    wait_idle("zero");
    checks++;
    if (doneCount != 1 || errCount != 0 || wrAddrQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_words: done=%0d err=%0d writes=%0d required 1 0 0",
               doneCount, errCount, wrAddrQ.size());
    end
  endtask

  task automatic test_too_many();
    clear_monitor();
    pulse_start(ADDR_W'(DEPTH + 1));
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL over_depth_now: err=%b busy=%b required err=1 busy=0", err, busy);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if (errCount != 1 || busyCount != 0 || doneCount != 0 || wrAddrQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL over_depth: err=%0d busyCycles=%0d done=%0d writes=%0d required 1 0 0 0",
               errCount, busyCount, doneCount, wrAddrQ.size());
    end
    clear_monitor();
    pulse_start(ADDR_W'(DEPTH));
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL at_depth: busy=%b err=%b required busy=1 err=0", busy, err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_gaps();
    logic [31:0] words [3];
    words[0] = 32'h12345678;
    words[1] = 32'h9ABCDEF0;
    words[2] = 32'h0F1E2D3C;
    clear_monitor();
    pulse_start(3);
    for (int w = 0; w < 3; w++) send_word(words[w], 3);
    send_checksum();
    wait_idle("gaps");
    checks++;
    if (wrAddrQ.size() != 3) begin
      errors++;
      $display("[TB] FAIL gaps_count: writes=%0d required 3", wrAddrQ.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wrAddrQ.size() || wrAddrQ[i] !== ADDR_W'(i) || wrDataQ[i] !== words[i]) begin
        errors++;
        if (i < wrAddrQ.size())
          $display("[TB] FAIL gaps_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                   i, wrAddrQ[i], wrDataQ[i], i, words[i]);
        else
          $display("[TB] FAIL gaps_write%0d: missing, required addr=%0d data=%h", i, i, words[i]);
      end
    end
    checks++;
    if (overlapCount != 0 || latencyBad != 0 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL gaps_timing: readyDuringWrite=%0d badLatency=%0d done=%0d required 0 0 1",
               overlapCount, latencyBad, doneCount);
    end
  endtask

  task automatic test_reset_midload();
    clear_monitor();
    pulse_start(2);
    send_byte(8'h4C, 0);
    send_byte(8'h00, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({byte_ready, wr_en, busy, cpu_hold, done, err} !== 6'b0 || wr_addr !== '0 || wr_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midload_reset: ctrl=%b addr=%h data=%h required 000000 0 0",
               {byte_ready, wr_en, busy, cpu_hold, done, err}, wr_addr, wr_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    pulse_start(1);
    send_word(32'hAABBCCDD, 0);
    send_checksum();
    wait_idle("midload");
    checks++;
    if (wrAddrQ.size() != 1 || wrAddrQ[0] !== '0 || wrDataQ[0] !== 32'hAABBCCDD) begin
      errors++;
      if (wrAddrQ.size() > 0)
        $display("[TB] FAIL midload_reload: writes=%0d addr=%0d data=%h required 1 0 aabbccdd",
                 wrAddrQ.size(), wrAddrQ[0], wrDataQ[0]);
      else
        $display("[TB] FAIL midload_reload: writes=0 required 1 write of aabbccdd at 0");
    end
    checks++;
    if (doneCount != 1) begin
      errors++;
      $display("[TB] FAIL midload_done: done=%0d required 1", doneCount);
    end
  endtask

  task automatic test_restart_ignored();
    clear_monitor();
    pulse_start(2);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    num_words = 5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    send_checksum();
    wait_idle("restart");
    checks++;
    if (wrAddrQ.size() != 2 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL restart_count: writes=%0d done=%0d required 2 1", wrAddrQ.size(), doneCount);
    end
    checks++;
    if (wrAddrQ.size() < 2 || wrAddrQ[1] !== ADDR_W'(1) || wrDataQ[1] !== 32'h55667788) begin
      errors++;
      if (wrAddrQ.size() >= 2)
        $display("[TB] FAIL restart_word1: addr=%0d data=%h required 1 55667788", wrAddrQ[1], wrDataQ[1]);
      else
        $display("[TB] FAIL restart_word1: missing, required addr 1 data 55667788");
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_monitor();
    pulse_start(1);
    send_word(32'h01020304, 0);
    send_byte(8'h04, 0);
    wait_idle("csum_ok");
    checks++;
    if (doneCount != 1 || errCount != 0 || wrAddrQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL csum_ok: done=%0d err=%0d writes=%0d required 1 0 1",
               doneCount, errCount, wrAddrQ.size());
    end
    clear_monitor();
    pulse_start(1);
    send_word(32'h01020304, 0);
    send_byte(8'h05, 0);
    wait_idle("csum_bad");
    checks++;
    if (doneCount != 0 || errCount != 1 || wrAddrQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL csum_bad: done=%0d err=%0d writes=%0d required 0 1 1",
               doneCount, errCount, wrAddrQ.size());
    end
  endtask
`endif

  initial begin
    $display("[TB] inst_loader bench starting");
    test_reset();
    test_two_words();
    test_zero_words();
    test_too_many();
    test_random_gaps();
    test_reset_midload();
    test_restart_ignored();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
